golden_ticket_queue: RTL and testbench
======================================

// Module: golden_ticket_queue
// PURPOSE
//  Sits between the hasher check logic and comm_uart, in the hash_clk domain.
//  Takes golden-ticket pulses from the second-hash compare and corrects each
//  nonce for the hasher pipeline depth. It drops back-to-back duplicates,
//  buffers the tickets and hands them to the comm side over a valid/ready
//  handshake, so bursts are not lost while the UART is busy transmitting.
// PARAMETERS
//  DEPTH         8      queue entries; power of 2, range 2..64
//  NONCE_OFFSET  32'd0  subtracted from every incoming nonce (pipeline latency fix)
//  CNT_W         8      width of the saturating drop counter
// PORTS
//  hash_clk            in   1      sole clock; all logic on posedge
//  reset_n             in   1      synchronous reset, active-low
//  rx_new_work         in   1      1-cycle pulse: new work loaded; flush all state
//  rx_new_ticket       in   1      1-cycle pulse: rx_ticket_nonce is a hit
//  rx_ticket_nonce     in   32     raw nonce2 value at the hit
//  tx_valid            out  1      head entry available
//  tx_nonce            out  32     corrected nonce at the head; stable while tx_valid & !tx_ready
//  tx_ready            in   1      consumer accepts the head this cycle
//  tx_level            out  clog2(DEPTH)+1  current occupancy
//  tx_dropped          out  CNT_W  overflow drops since reset/flush; saturates at all-ones
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): tx_valid=0, tx_nonce=0, tx_level=0,
//    tx_dropped=0; stage register and last-accepted record cleared.
//  - Stage S1 (registered): adj = rx_ticket_nonce - NONCE_OFFSET, mod 2^32
//    (wraps; 0 - 1 = 32'hFFFFFFFF). S1 holds s1_vld and s1_nonce.
//  - Dedupe at S1 output: if last_vld and s1_nonce == last_nonce, drop the
//    entry silently (tx_dropped unchanged). Otherwise write it, and update
//    last_nonce and last_vld=1 on every write attempt, including an
//    overflow drop.
//  - Write: on a non-duplicate S1 entry, push if level<DEPTH or a pop
//    happens in the same cycle. Otherwise drop and increment tx_dropped
//    (saturating).
//  - Pop: tx_valid & tx_ready at posedge removes the head.
//  - Latency: pulse sampled at edge k, written at edge k+1, tx_valid=1 in
//    the cycle after edge k+1. This is 2 cycles into an empty queue.
//  - First-word-fall-through: tx_nonce is the head entry whenever tx_valid=1.
//    It holds its last value when empty.
//  - Simultaneous push and pop: level unchanged, both take effect.
//    Push+pop when empty: the entry is written and not popped, because
//    tx_valid was 0.
//  - rx_new_work (highest priority after reset): at that edge, clear the
//    queue (level=0, tx_valid=0), clear S1, clear last_vld and clear
//    tx_dropped. An rx_new_ticket in the same cycle is discarded as stale.
//    A pop in the same cycle is ignored.
//  - The pointers are log2(DEPTH) bits and wrap naturally. Full and empty
//    are decided from the level count, not from pointer equality.
//  - No state machine beyond the FIFO. All outputs are registered except
//    tx_nonce, which is a registered-memory read via the head pointer.
// STRUCTURE
//  - Shared package miner_pkg: NONCE_W=32, default GT_QUEUE_DEPTH=8,
//    constant GT_NONCE_OFFSET. The top and comm_uart use the same
//    constants.
//  - One sub-module, gt_sync_fifo. It is a parameterized single-clock FWFT
//    FIFO with ports wr_en/wr_data/full, rd_en/rd_data/empty, level and
//    clr, using the same synchronous active-low reset.
//  - golden_ticket_queue = S1 stage + dedupe + drop counter + gt_sync_fifo.
// TESTING
//  1. NONCE_OFFSET=5: ticket 32'h00000105 at edge 0, tx_ready=1 ->
//     tx_valid one cycle after edge 1, tx_nonce=32'h00000100, popped,
//     level returns to 0.
//  2. Wrap: NONCE_OFFSET=5, ticket 32'h00000002 -> tx_nonce=32'hFFFFFFFD.
//  3. Dedupe: tickets A, A, B, A on consecutive cycles, tx_ready=0 ->
//     level=3, order A, B, A; tx_dropped=0.
//  4. Overflow: DEPTH=8, tx_ready=0, 10 distinct tickets -> level=8,
//     tx_dropped=2, heads are the first 8 in order. Then push and pop in
//     the same cycle while full -> level stays 8, no drop.
//  5. Flush: 3 queued entries, rx_new_work with a same-cycle ticket ->
//     next cycle tx_valid=0, level=0, tx_dropped=0, ticket absent. The
//     nonce that was last before the flush is then accepted again
//     (last_vld was cleared).
//  6. Reset mid-stream: reset_n=0 for 1 cycle with 4 entries queued and
//     an S1 hit pending -> all outputs at reset values, nothing emitted
//     afterwards.
//  Bench checks every cycle: tx_nonce stable while tx_valid & !tx_ready,
//  and output order matches a scoreboard queue.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared miner constants: nonce width, default golden-ticket queue depth and
// the hasher pipeline latency correction applied to reported nonces.
package miner_pkg;

    localparam int NONCE_W = 32;
    localparam int GT_QUEUE_DEPTH = 8;
    localparam logic [NONCE_W-1:0] GT_NONCE_OFFSET = 32'd0;

    typedef logic [NONCE_W-1:0] nonce_t;

endpackage

// File: rtl/gt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Occupancy is tracked with an
// explicit level counter so full/empty never depend on pointer equality.
// When empty, rd_data keeps showing the last entry that left the head.
module gt_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              do_wr, do_rd;

    assign empty   = (level_q == '0);
    assign full    = (level_q == DEPTH_L);
    assign level   = level_q;
    assign rd_data = empty ? hold_q : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and the empty-hold register
    always_comb begin
        do_rd    = rd_en & ~empty & ~clr;
        do_wr    = wr_en & (~full | do_rd) & ~clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hold_d   = hold_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            if (!empty) begin
                hold_d = mem_q[rd_ptr_q];
            end
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                hold_d   = mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control and hold registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/golden_ticket_queue.sv
// Golden-ticket queue: registers each hit with its pipeline-latency-corrected
// nonce, drops back-to-back duplicates, and buffers tickets in an FWFT FIFO
// for the UART side. Overflow drops are counted with a saturating counter.
module golden_ticket_queue
    import miner_pkg::*;
#(
    parameter int     DEPTH        = GT_QUEUE_DEPTH,
    parameter nonce_t NONCE_OFFSET = GT_NONCE_OFFSET,
    parameter int     CNT_W        = 8
) (
    input  logic                   hash_clk,
    input  logic                   reset_n,
    input  logic                   rx_new_work,
    input  logic                   rx_new_ticket,
    input  logic [NONCE_W-1:0]     rx_ticket_nonce,
    output logic                   tx_valid,
    output logic [NONCE_W-1:0]     tx_nonce,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [CNT_W-1:0]       tx_dropped
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic         s1_vld_q, s1_vld_d;
    nonce_t       s1_nonce_q, s1_nonce_d;
    logic         last_vld_q, last_vld_d;
    nonce_t       last_nonce_q, last_nonce_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;

    logic fifo_full, fifo_empty;
    logic pop, dup, wr_try;

    assign pop        = tx_valid & tx_ready;
    assign dup        = s1_vld_q & last_vld_q & (s1_nonce_q == last_nonce_q);
    assign wr_try     = s1_vld_q & ~dup & ~rx_new_work;
    assign tx_valid   = ~fifo_empty;
    assign tx_dropped = dropped_q;

    // Stage S1 capture, dedupe record and overflow drop counting
    always_comb begin
        s1_vld_d     = rx_new_ticket & ~rx_new_work;
        s1_nonce_d   = rx_ticket_nonce - NONCE_OFFSET;
        last_vld_d   = last_vld_q;
        last_nonce_d = last_nonce_q;
        dropped_d    = dropped_q;

        if (rx_new_work) begin
            last_vld_d = 1'b0;
            dropped_d  = '0;
        end else if (wr_try) begin
            // Record updates on every attempt, so a dropped ticket still dedupes its repeat
            last_vld_d   = 1'b1;
            last_nonce_d = s1_nonce_q;
            if (fifo_full && !pop) begin
                dropped_d = sat_inc(dropped_q);
            end
        end
    end

    // S1 / dedupe / counter registers, synchronous active-low reset
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            s1_vld_q     <= 1'b0;
            s1_nonce_q   <= '0;
            last_vld_q   <= 1'b0;
            last_nonce_q <= '0;
            dropped_q    <= '0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_nonce_q   <= s1_nonce_d;
            last_vld_q   <= last_vld_d;
            last_nonce_q <= last_nonce_d;
            dropped_q    <= dropped_d;
        end
    end

    gt_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (NONCE_W)
    ) u_fifo (
        .clk     (hash_clk),
        .rst_n   (reset_n),
        .clr     (rx_new_work),
        .wr_en   (wr_try),
        .wr_data (s1_nonce_q),
        .full    (fifo_full),
        .rd_en   (tx_ready),
        .rd_data (tx_nonce),
        .empty   (fifo_empty),
        .level   (tx_level)
    );

endmodule

// File: tb/tb_golden_ticket_queue.sv
// Bench for golden_ticket_queue: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_golden_ticket_queue;

    localparam int          DEPTH = 8;
    localparam int          CNT_W = 8;
    localparam logic [31:0] OFF   = 32'd5;

    logic        hash_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_new_work = 1'b0;
    logic        rx_new_ticket = 1'b0;
    logic [31:0] rx_ticket_nonce = '0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [31:0] tx_nonce;
    logic [3:0]  tx_level;
    logic [7:0]  tx_dropped;

    golden_ticket_queue #(
        .DEPTH        (DEPTH),
        .NONCE_OFFSET (OFF),
        .CNT_W        (CNT_W)
    ) dut (
        .hash_clk        (hash_clk),
        .reset_n         (reset_n),
        .rx_new_work     (rx_new_work),
        .rx_new_ticket   (rx_new_ticket),
        .rx_ticket_nonce (rx_ticket_nonce),
        .tx_valid        (tx_valid),
        .tx_nonce        (tx_nonce),
        .tx_ready        (tx_ready),
        .tx_level        (tx_level),
        .tx_dropped      (tx_dropped)
    );

    always #5 hash_clk = ~hash_clk;

    // Reference model: queue contents, pending S1 ticket, last accepted nonce
    logic [31:0] mq[$];
    int          m_drop;
    bit          m_pend_vld;
    logic [31:0] m_pend;
    bit          m_last_vld;
    logic [31:0] m_last;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit          nw;
        bit          tk;
        logic [31:0] nn;
        bit          rdy;
        bit          ev;
        logic [31:0] en;
        int          el;
        int          ed;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input bit rstn, input bit nw, input bit tk,
                              input logic [31:0] nn, input bit rdy);
        bit pop;
        int sz;
        if (!rstn || nw) begin
            mq.delete();
            m_drop     = 0;
            m_pend_vld = 0;
            m_last_vld = 0;
        end else begin
            sz  = mq.size();
            pop = rdy && (sz > 0);
            if (pop) void'(mq.pop_front());
            if (m_pend_vld && !(m_last_vld && m_pend == m_last)) begin
                m_last     = m_pend;
                m_last_vld = 1;
                if (sz < DEPTH || pop) mq.push_back(m_pend);
                else if (m_drop < (1 << CNT_W) - 1) m_drop++;
            end
            m_pend_vld = tk;
            m_pend     = nn - OFF;
        end
    endtask

    task automatic cyc(input bit nw, input bit tk, input logic [31:0] nn,
                       input bit rdy, input bit rstn = 1'b1);
        bit          hold;
        logic [31:0] held;
        hold = (tx_valid === 1'b1) && !rdy && !nw && rstn;
        held = tx_nonce;
        reset_n         = rstn;
        rx_new_work     = nw;
        rx_new_ticket   = tk;
        rx_ticket_nonce = nn;
        tx_ready        = rdy;
        @(posedge hash_clk);
        model_edge(rstn, nw, tk, nn, rdy);
        @(negedge hash_clk);
        if (hold) chk("stable", tx_nonce, held);
        chk("m_valid", 32'(tx_valid), 32'(mq.size() != 0));
        chk("m_level", 32'(tx_level), mq.size());
        chk("m_dropped", 32'(tx_dropped), m_drop);
        if (mq.size() != 0) chk("m_head", tx_nonce, mq[0]);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(0, 0, 32'h0, rdy);
    endtask

    initial begin
        vt[0]  = '{0, 1, 32'h00000105, 1, 0, 32'h0,        0, 0};
        vt[1]  = '{0, 0, 32'h0,        1, 1, 32'h00000100, 1, 0};
        vt[2]  = '{0, 0, 32'h0,        1, 0, 32'h0,        0, 0};
        vt[3]  = '{0, 1, 32'h00000002, 0, 0, 32'h0,        0, 0};
        vt[4]  = '{0, 0, 32'h0,        0, 1, 32'hFFFFFFFD, 1, 0};
        vt[5]  = '{0, 0, 32'h0,        1, 0, 32'h0,        0, 0};
        vt[6]  = '{0, 1, 32'h00001005, 0, 0, 32'h0,        0, 0};
        vt[7]  = '{0, 1, 32'h00001005, 0, 1, 32'h00001000, 1, 0};
        vt[8]  = '{0, 1, 32'h00002005, 0, 1, 32'h00001000, 1, 0};
        vt[9]  = '{0, 1, 32'h00001005, 0, 1, 32'h00001000, 2, 0};
        vt[10] = '{0, 0, 32'h0,        0, 1, 32'h00001000, 3, 0};
        vt[11] = '{0, 0, 32'h0,        1, 1, 32'h00002000, 2, 0};
        vt[12] = '{0, 0, 32'h0,        1, 1, 32'h00001000, 1, 0};
        vt[13] = '{0, 0, 32'h0,        1, 0, 32'h0,        0, 0};

        @(negedge hash_clk);
        cyc(0, 1, 32'h1234, 0, 0);
        cyc(0, 0, 32'h0, 0, 0);
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_nonce", tx_nonce, 32'h0);
        chk("rst_level", 32'(tx_level), 32'h0);
        chk("rst_dropped", 32'(tx_dropped), 32'h0);

        // Latency, wrap and dedupe vectors
        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].nw, vt[i].tk, vt[i].nn, vt[i].rdy);
            chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vt[i].ev));
            if (vt[i].ev) chk($sformatf("vec%0d_nonce", i), tx_nonce, vt[i].en);
            chk($sformatf("vec%0d_level", i), 32'(tx_level), vt[i].el);
            chk($sformatf("vec%0d_dropped", i), 32'(tx_dropped), vt[i].ed);
        end

        // Overflow: 10 distinct tickets into a depth-8 queue
        for (int i = 0; i < 10; i++) cyc(0, 1, 32'h5005 + 32'(i * 16), 0);
        idle(1, 0);
        chk("ovf_level", 32'(tx_level), 32'd8);
        chk("ovf_dropped", 32'(tx_dropped), 32'd2);
        chk("ovf_head", tx_nonce, 32'h5000);
        cyc(0, 1, 32'h9005, 0);
        cyc(0, 0, 32'h0, 1);
        chk("full_pushpop_level", 32'(tx_level), 32'd8);
        chk("full_pushpop_dropped", 32'(tx_dropped), 32'd2);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("drain%0d", i), tx_nonce, (i < 8) ? 32'h5000 + 32'(i * 16) : 32'h9000);
            cyc(0, 0, 32'h0, 1);
        end
        chk("drain_level", 32'(tx_level), 32'd0);

        // Flush with a same-cycle ticket, then the pre-flush last nonce again
        cyc(0, 1, 32'h6005, 0);
        cyc(0, 1, 32'h7005, 0);
        cyc(0, 1, 32'h8005, 0);
        idle(1, 0);
        chk("preflush_level", 32'(tx_level), 32'd3);
        cyc(1, 1, 32'hA005, 0);
        chk("flush_valid", 32'(tx_valid), 32'h0);
        chk("flush_level", 32'(tx_level), 32'h0);
        chk("flush_dropped", 32'(tx_dropped), 32'h0);
        idle(2, 0);
        chk("flush_stale", 32'(tx_level), 32'h0);
        cyc(0, 1, 32'h8005, 0);
        idle(1, 0);
        chk("reaccept_level", 32'(tx_level), 32'd1);
        chk("reaccept_head", tx_nonce, 32'h8000);
        idle(1, 1);

        // Reset mid-stream with 4 queued and one S1 hit pending
        for (int i = 0; i < 5; i++) cyc(0, 1, 32'hB005 + 32'(i * 16), 0);
        chk("prerst_level", 32'(tx_level), 32'd4);
        cyc(0, 0, 32'h0, 0, 0);
        chk("midrst_valid", 32'(tx_valid), 32'h0);
        chk("midrst_nonce", tx_nonce, 32'h0);
        chk("midrst_level", 32'(tx_level), 32'h0);
        chk("midrst_dropped", 32'(tx_dropped), 32'h0);
        idle(3, 1);
        chk("postrst_valid", 32'(tx_valid), 32'h0);

        // Drop counter saturation
        for (int i = 0; i < DEPTH + 260; i++) cyc(0, 1, 32'h20000 + 32'(i), 0);
        idle(1, 0);
        chk("sat_dropped", 32'(tx_dropped), 32'hFF);
        chk("sat_level", 32'(tx_level), 32'd8);
        cyc(1, 0, 32'h0, 0);

        // Randomized traffic with a small nonce alphabet to exercise dedupe and wrap
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 63) == 0,
                $urandom_range(0, 1) == 1,
                32'h00000100 + 32'($urandom_range(0, 5)) - 32'($urandom_range(0, 1) * 32'h100),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 199) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
